// File: rtl/aes_out_serializer.sv
// aes_out_serializer: captures aes_engine result packets into a packet FIFO
// and streams each 128-bit result as four 32-bit words, most significant
// word first, over a valid/ready interface. Packets arriving while the FIFO
// is full (and nothing leaves that cycle) are dropped, flagged and counted.

package aes_pkg;
    typedef struct packed {
        logic [127:0] data;
        logic         en_de;
        logic         valid;
    } out_packet_t;
endpackage

module aes_out_serializer
    import aes_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  out_packet_t            pkt_in,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [31:0]            m_data,
    output logic                   m_last,
    output logic                   m_en_de,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic [CNT_W-1:0]       drop_cnt
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;

    localparam logic [CW-1:0]    FULL_C    = CW'(DEPTH);
    localparam logic [CW-1:0]    ZERO_C    = CW'(0);
    localparam logic [CW-1:0]    ONE_C     = CW'(1);
    localparam logic [PTR_W-1:0] PTR_ONE_C = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX_C = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE_C = CNT_W'(1);

    typedef enum logic [0:0] {
        IDLE_S = 1'b0,
        SEND_S = 1'b1
    } state_t;

    // Packet storage: {en_de, data}
    logic [128:0]     mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_nxt_s;
    logic             overflow_r;
    logic [CNT_W-1:0] drop_cnt_r;

    // Serializer state
    state_t       state_r;
    state_t       state_nxt_s;
    logic [127:0] shift_r;
    logic [127:0] shift_nxt_s;
    logic [1:0]   idx_r;
    logic [1:0]   idx_nxt_s;
    logic         m_valid_r;
    logic         m_valid_nxt_s;
    logic         m_last_r;
    logic         m_last_nxt_s;
    logic         m_en_de_r;
    logic         m_en_de_nxt_s;

    logic         pop_s;
    logic         push_s;
    logic         drop_s;
    logic         full_s;
    logic [128:0] head_s;

    assign head_s = mem_r[rd_ptr_r];
    assign full_s = (count_r == FULL_C);

    // Serializer next-state: load on pop, shift left one word per handshake
    always_comb begin
        state_nxt_s   = state_r;
        pop_s         = 1'b0;
        shift_nxt_s   = shift_r;
        idx_nxt_s     = idx_r;
        m_valid_nxt_s = m_valid_r;
        m_last_nxt_s  = m_last_r;
        m_en_de_nxt_s = m_en_de_r;
        case (state_r)
            IDLE_S: begin
                if (count_r != ZERO_C) begin
                    pop_s         = 1'b1;
                    state_nxt_s   = SEND_S;
                    shift_nxt_s   = head_s[127:0];
                    idx_nxt_s     = 2'd0;
                    m_valid_nxt_s = 1'b1;
                    m_last_nxt_s  = 1'b0;
                    m_en_de_nxt_s = head_s[128];
                end else begin
                    state_nxt_s   = IDLE_S;
                    m_valid_nxt_s = 1'b0;
                    m_last_nxt_s  = 1'b0;
                end
            end
            SEND_S: begin
                if (m_ready) begin
                    if (idx_r == 2'd3) begin
                        if (count_r != ZERO_C) begin
                            // Chain straight into the next packet: no bubble
                            pop_s         = 1'b1;
                            state_nxt_s   = SEND_S;
                            shift_nxt_s   = head_s[127:0];
                            idx_nxt_s     = 2'd0;
                            m_valid_nxt_s = 1'b1;
                            m_last_nxt_s  = 1'b0;
                            m_en_de_nxt_s = head_s[128];
                        end else begin
                            state_nxt_s   = IDLE_S;
                            shift_nxt_s   = 128'd0;
                            idx_nxt_s     = 2'd0;
                            m_valid_nxt_s = 1'b0;
                            m_last_nxt_s  = 1'b0;
                            m_en_de_nxt_s = 1'b0;
                        end
                    end else begin
                        shift_nxt_s  = {shift_r[95:0], 32'd0};
                        idx_nxt_s    = idx_r + 2'd1;
                        m_last_nxt_s = (idx_r == 2'd2);
                    end
                end else begin
                    // Stalled: every output holds
                    state_nxt_s = SEND_S;
                end
            end
            default: begin
                state_nxt_s   = IDLE_S;
                shift_nxt_s   = 128'd0;
                idx_nxt_s     = 2'd0;
                m_valid_nxt_s = 1'b0;
                m_last_nxt_s  = 1'b0;
                m_en_de_nxt_s = 1'b0;
            end
        endcase
    end

    // FIFO write/drop decision; a same-cycle pop frees a slot for the arrival
    always_comb begin
        push_s = 1'b0;
        drop_s = 1'b0;
        if (pkt_in.valid) begin
            if (!full_s || pop_s) begin
                push_s = 1'b1;
            end else begin
                drop_s = 1'b1;
            end
        end else begin
            push_s = 1'b0;
            drop_s = 1'b0;
        end
    end

    // Occupancy update from push/pop combination
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + ONE_C;
            2'b01:   count_nxt_s = count_r - ONE_C;
            default: count_nxt_s = count_r;
        endcase
    end

    // Serializer state and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE_S;
            shift_r   <= 128'd0;
            idx_r     <= 2'd0;
            m_valid_r <= 1'b0;
            m_last_r  <= 1'b0;
            m_en_de_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            shift_r   <= shift_nxt_s;
            idx_r     <= idx_nxt_s;
            m_valid_r <= m_valid_nxt_s;
            m_last_r  <= m_last_nxt_s;
            m_en_de_r <= m_en_de_nxt_s;
        end
    end

    // FIFO pointers, occupancy and drop bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= ZERO_C;
            overflow_r <= 1'b0;
            drop_cnt_r <= {CNT_W{1'b0}};
        end else begin
            count_r <= count_nxt_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
                if (drop_cnt_r != CNT_MAX_C) begin
                    drop_cnt_r <= drop_cnt_r + CNT_ONE_C;
                end
            end
        end
    end

    // Packet storage write port (contents need no reset; pointers qualify them)
    always_ff @(posedge clk) begin
        if (!rst && push_s) begin
            mem_r[wr_ptr_r] <= {pkt_in.en_de, pkt_in.data};
        end
    end

    assign m_valid  = m_valid_r;
    assign m_data   = shift_r[127:96];
    assign m_last   = m_last_r;
    assign m_en_de  = m_en_de_r;
    assign count    = count_r;
    assign overflow = overflow_r;
    assign drop_cnt = drop_cnt_r;

endmodule

// File: tb/tb_aes_out_serializer.sv
// Testbench for aes_out_serializer: randomized packets checked against a
// transaction-level model (packet occupancy + expected word stream).

module tb_aes_out_serializer;
    import aes_pkg::*;

    localparam int DEPTH = 8;
    localparam int CNT_W = 16;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    out_packet_t            pkt_in;
    logic                   m_valid;
    logic                   m_ready;
    logic [31:0]            m_data;
    logic                   m_last;
    logic                   m_en_de;
    logic [$clog2(DEPTH):0] count;
    logic                   overflow;
    logic [CNT_W-1:0]       drop_cnt;

    int vectors     = 0;
    int miscompares = 0;

    // Observed and expected word streams: {last, en_de, data}
    logic [33:0] obs_q[$];
    logic [33:0] exp_q[$];

    // Transaction-level model
    int mq_cnt;
    bit m_busy;
    int m_left;
    bit md_ovf;
    int md_drops;

    aes_out_serializer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .pkt_in   (pkt_in),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_last   (m_last),
        .m_en_de  (m_en_de),
        .count    (count),
        .overflow (overflow),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One clock: apply inputs, record a handshake, advance the model
    task automatic drive_cycle(input logic v, input logic [127:0] d, input logic e, input logic r);
        bit hs, fin, pop, acc;
        pkt_in.valid = v;
        pkt_in.data  = d;
        pkt_in.en_de = e;
        m_ready      = r;
        if (!rst && m_valid && m_ready) obs_q.push_back({m_last, m_en_de, m_data});
        @(posedge clk);
        if (rst) begin
            mq_cnt = 0; m_busy = 0; m_left = 0; md_ovf = 0; md_drops = 0;
            obs_q.delete();
            exp_q.delete();
        end else begin
            hs  = m_busy && r;
            fin = hs && (m_left == 1);
            pop = (!m_busy || fin) && (mq_cnt > 0);
            acc = v && ((mq_cnt < DEPTH) || pop);
            if (v && !acc) begin
                md_ovf = 1;
                if (md_drops < (1 << CNT_W) - 1) md_drops++;
            end
            if (acc) begin
                for (int k = 0; k < 4; k++)
                    exp_q.push_back({(k == 3), e, d[127 - 32*k -: 32]});
            end
            mq_cnt = mq_cnt + int'(acc) - int'(pop);
            if (pop) begin
                m_busy = 1; m_left = 4;
            end else if (fin) begin
                m_busy = 0; m_left = 0;
            end else if (hs) begin
                m_left--;
            end
        end
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        drive_cycle(1'b0, 128'd0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        reset_dut();
        reset_dut();
        vectors += 7;
        if (m_valid !== 1'b0)   begin miscompares++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
        if (m_data !== 32'd0)   begin miscompares++; $display("FAIL reset_m_data: got %h want 0", m_data); end
        if (m_last !== 1'b0)    begin miscompares++; $display("FAIL reset_m_last: got %b want 0", m_last); end
        if (m_en_de !== 1'b0)   begin miscompares++; $display("FAIL reset_m_en_de: got %b want 0", m_en_de); end
        if (count !== '0)       begin miscompares++; $display("FAIL reset_count: got %0d want 0", count); end
        if (overflow !== 1'b0)  begin miscompares++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        if (drop_cnt !== '0)    begin miscompares++; $display("FAIL reset_drop_cnt: got %0d want 0", drop_cnt); end
    endtask

    task automatic test_single();
        logic [127:0] pkt;
        logic [31:0]  exp_w [4];
        pkt      = 128'h00112233_44556677_8899aabb_ccddeeff;
        exp_w[0] = 32'h00112233;
        exp_w[1] = 32'h44556677;
        exp_w[2] = 32'h8899aabb;
        exp_w[3] = 32'hccddeeff;
        reset_dut();
        drive_cycle(1'b1, pkt, 1'b1, 1'b1);
        vectors++;
        if (m_valid !== 1'b0) begin miscompares++; $display("FAIL single_latency: m_valid %b after edge N, want 0", m_valid); end
        for (int k = 0; k < 4; k++) begin
            drive_cycle(1'b0, 128'd0, 1'b0, 1'b1);
            vectors += 4;
            if (m_valid !== 1'b1)           begin miscompares++; $display("FAIL single_valid w%0d: got %b want 1", k, m_valid); end
            if (m_data !== exp_w[k])        begin miscompares++; $display("FAIL single_data w%0d: got %h want %h", k, m_data, exp_w[k]); end
            if (m_last !== (k == 3))        begin miscompares++; $display("FAIL single_last w%0d: got %b want %b", k, m_last, (k == 3)); end
            if (m_en_de !== 1'b1)           begin miscompares++; $display("FAIL single_en_de w%0d: got %b want 1", k, m_en_de); end
        end
        drive_cycle(1'b0, 128'd0, 1'b0, 1'b1);
        vectors++;
        if (m_valid !== 1'b0) begin miscompares++; $display("FAIL single_idle: m_valid %b want 0", m_valid); end
    endtask

    task automatic test_backpressure();
        logic [6:0]  pat;
        logic [33:0] prev;
        int          hs_cnt;
        bit          stalled;
        pat    = 7'b1101001;
        hs_cnt = 0;
        reset_dut();
        drive_cycle(1'b1, rand128(), 1'($urandom_range(0, 1)), 1'b0);
        drive_cycle(1'b0, 128'd0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            prev    = {m_last, m_en_de, m_data};
            stalled = m_valid && !pat[i];
            if (m_valid && pat[i]) hs_cnt++;
            drive_cycle(1'b0, 128'd0, 1'b0, pat[i]);
            if (stalled) begin
                vectors += 2;
                if (m_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid_drop c%0d: got %b want 1", i, m_valid); end
                if ({m_last, m_en_de, m_data} !== prev) begin
                    miscompares++; $display("FAIL bp_hold c%0d: got %h want %h", i, {m_last, m_en_de, m_data}, prev);
                end
            end
        end
        vectors += 3;
        if (hs_cnt != 4) begin miscompares++; $display("FAIL bp_handshakes: got %0d want 4", hs_cnt); end
        if (m_valid !== 1'b0) begin miscompares++; $display("FAIL bp_end_valid: got %b want 0", m_valid); end
        if (obs_q.size() != 4) begin miscompares++; $display("FAIL bp_words: got %0d want 4", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL bp_word %0d: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_burst();
        logic [127:0] first;
        reset_dut();
        first = rand128();
        drive_cycle(1'b1, first, 1'b1, 1'b0);
        for (int i = 1; i < DEPTH + 2; i++) drive_cycle(1'b1, rand128(), 1'($urandom_range(0, 1)), 1'b0);
        vectors += 5;
        if (count !== DEPTH)      begin miscompares++; $display("FAIL burst_count: got %0d want %0d", count, DEPTH); end
        if (overflow !== 1'b1)    begin miscompares++; $display("FAIL burst_overflow: got %b want 1", overflow); end
        if (drop_cnt !== 16'd1)   begin miscompares++; $display("FAIL burst_drop_cnt: got %0d want 1", drop_cnt); end
        if (m_valid !== 1'b1)     begin miscompares++; $display("FAIL burst_valid: got %b want 1", m_valid); end
        if (m_data !== first[127:96]) begin miscompares++; $display("FAIL burst_head: got %h want %h", m_data, first[127:96]); end
        for (int i = 0; i < 4 * (DEPTH + 1) + 4; i++) drive_cycle(1'b0, 128'd0, 1'b0, 1'b1);
        vectors += 3;
        if (obs_q.size() != 4 * (DEPTH + 1)) begin miscompares++; $display("FAIL burst_words: got %0d want %0d", obs_q.size(), 4 * (DEPTH + 1)); end
        if (overflow !== 1'b1) begin miscompares++; $display("FAIL burst_sticky: got %b want 1", overflow); end
        if (count !== '0)      begin miscompares++; $display("FAIL burst_drained: got %0d want 0", count); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL burst_word %0d: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_full_pop();
        reset_dut();
        for (int i = 0; i < DEPTH + 1; i++) drive_cycle(1'b1, rand128(), 1'($urandom_range(0, 1)), 1'b0);
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 128'd0, 1'b0, 1'b1);
        vectors += 2;
        if (count !== DEPTH)  begin miscompares++; $display("FAIL fullpop_pre_count: got %0d want %0d", count, DEPTH); end
        if (m_last !== 1'b1)  begin miscompares++; $display("FAIL fullpop_pre_last: got %b want 1", m_last); end
        drive_cycle(1'b1, rand128(), 1'($urandom_range(0, 1)), 1'b1);
        vectors += 3;
        if (count !== DEPTH)    begin miscompares++; $display("FAIL fullpop_count: got %0d want %0d", count, DEPTH); end
        if (drop_cnt !== 16'd0) begin miscompares++; $display("FAIL fullpop_drop_cnt: got %0d want 0", drop_cnt); end
        if (overflow !== 1'b0)  begin miscompares++; $display("FAIL fullpop_overflow: got %b want 0", overflow); end
        for (int i = 0; i < 4 * (DEPTH + 1) + 4; i++) drive_cycle(1'b0, 128'd0, 1'b0, 1'b1);
        vectors++;
        if (obs_q.size() != 4 * (DEPTH + 2)) begin miscompares++; $display("FAIL fullpop_words: got %0d want %0d", obs_q.size(), 4 * (DEPTH + 2)); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL fullpop_word %0d: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_back_to_back();
        int cyc, first_hi, last_hi, hi_cnt;
        cyc = 0; first_hi = -1; last_hi = -1; hi_cnt = 0;
        reset_dut();
        for (int p = 0; p < 24; p++) begin
            for (int c = 0; c < 4; c++) begin
                if (p < 20 && c == 0) drive_cycle(1'b1, rand128(), 1'($urandom_range(0, 1)), 1'b1);
                else                  drive_cycle(1'b0, 128'd0, 1'b0, 1'b1);
                cyc++;
                if (m_valid === 1'b1) begin
                    if (first_hi < 0) first_hi = cyc;
                    last_hi = cyc;
                    hi_cnt++;
                end
            end
        end
        vectors += 4;
        if (hi_cnt != 80) begin miscompares++; $display("FAIL b2b_valid_cycles: got %0d want 80", hi_cnt); end
        if (last_hi - first_hi + 1 != hi_cnt) begin miscompares++; $display("FAIL b2b_gap: span %0d vs high %0d", last_hi - first_hi + 1, hi_cnt); end
        if (overflow !== 1'b0) begin miscompares++; $display("FAIL b2b_overflow: got %b want 0", overflow); end
        if (obs_q.size() != 80) begin miscompares++; $display("FAIL b2b_words: got %0d want 80", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL b2b_word %0d: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        bit v, r;
        reset_dut();
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 99) < 40);
            r = ($urandom_range(0, 99) < 50);
            drive_cycle(v, rand128(), 1'($urandom_range(0, 1)), r);
            vectors += 4;
            if (count !== mq_cnt)      begin miscompares++; $display("FAIL rand_count c%0d: got %0d want %0d", i, count, mq_cnt); end
            if (m_valid !== m_busy)    begin miscompares++; $display("FAIL rand_valid c%0d: got %b want %b", i, m_valid, m_busy); end
            if (overflow !== md_ovf)   begin miscompares++; $display("FAIL rand_overflow c%0d: got %b want %b", i, overflow, md_ovf); end
            if (drop_cnt !== md_drops) begin miscompares++; $display("FAIL rand_drop_cnt c%0d: got %0d want %0d", i, drop_cnt, md_drops); end
        end
        for (int i = 0; i < 4 * (DEPTH + 1) + 8; i++) drive_cycle(1'b0, 128'd0, 1'b0, 1'b1);
        vectors++;
        if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL rand_words: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL rand_word %0d: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid();
        int stale;
        stale = 0;
        reset_dut();
        for (int i = 0; i < 4; i++) drive_cycle(1'b1, rand128(), 1'b1, 1'b0);
        drive_cycle(1'b0, 128'd0, 1'b0, 1'b1);
        drive_cycle(1'b0, 128'd0, 1'b0, 1'b1);
        vectors++;
        if (count !== 3) begin miscompares++; $display("FAIL rstmid_pre_count: got %0d want 3", count); end
        reset_dut();
        vectors += 7;
        if (m_valid !== 1'b0)  begin miscompares++; $display("FAIL rstmid_m_valid: got %b want 0", m_valid); end
        if (m_data !== 32'd0)  begin miscompares++; $display("FAIL rstmid_m_data: got %h want 0", m_data); end
        if (m_last !== 1'b0)   begin miscompares++; $display("FAIL rstmid_m_last: got %b want 0", m_last); end
        if (m_en_de !== 1'b0)  begin miscompares++; $display("FAIL rstmid_m_en_de: got %b want 0", m_en_de); end
        if (count !== '0)      begin miscompares++; $display("FAIL rstmid_count: got %0d want 0", count); end
        if (overflow !== 1'b0) begin miscompares++; $display("FAIL rstmid_overflow: got %b want 0", overflow); end
        if (drop_cnt !== '0)   begin miscompares++; $display("FAIL rstmid_drop_cnt: got %0d want 0", drop_cnt); end
        for (int i = 0; i < 12; i++) begin
            drive_cycle(1'b0, 128'd0, 1'b0, 1'b1);
            if (m_valid !== 1'b0) stale++;
        end
        vectors += 2;
        if (stale != 0)        begin miscompares++; $display("FAIL rstmid_stale_valid: got %0d cycles want 0", stale); end
        if (obs_q.size() != 0) begin miscompares++; $display("FAIL rstmid_stale_words: got %0d want 0", obs_q.size()); end
    endtask

    initial begin
        pkt_in  = '0;
        m_ready = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_burst();
        test_full_pop();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
